// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, control field layout and
// per-opcode control constants.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int unsigned WB_W  = 2;
    localparam int unsigned MEM_W = 3;
    localparam int unsigned EX_W  = 4;

    // Bit positions inside the control groups
    localparam int unsigned WB_REG_WRITE  = 1;
    localparam int unsigned WB_MEM_TO_REG = 0;
    localparam int unsigned MEM_BRANCH    = 2;
    localparam int unsigned MEM_READ      = 1;
    localparam int unsigned MEM_WRITE     = 0;
    localparam int unsigned EX_REG_DST    = 3;
    localparam int unsigned EX_ALU_SRC    = 0;

    typedef struct packed {
        logic             legal;
        logic             uses_rt;
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } ctl_t;

    localparam ctl_t CTL_RTYPE = '{1'b1, 1'b1, 2'b10, 3'b000, 4'b1100};
    localparam ctl_t CTL_LW    = '{1'b1, 1'b0, 2'b11, 3'b010, 4'b0001};
    localparam ctl_t CTL_SW    = '{1'b1, 1'b1, 2'b00, 3'b001, 4'b0001};
    localparam ctl_t CTL_BEQ   = '{1'b1, 1'b1, 2'b00, 3'b100, 4'b0100};
    localparam ctl_t CTL_ADDI  = '{1'b1, 1'b0, 2'b10, 3'b000, 4'b0001};
    localparam ctl_t CTL_NONE  = '{1'b0, 1'b0, 2'b00, 3'b000, 4'b0000};

    // Unknown opcodes (including 0x20) decode to all-zero control, legal=0
    function automatic ctl_t decode_ctl(input logic [5:0] op);
        ctl_t c;
        case (op)
            OP_RTYPE: c = CTL_RTYPE;
            OP_LW:    c = CTL_LW;
            OP_SW:    c = CTL_SW;
            OP_BEQ:   c = CTL_BEQ;
            OP_ADDI:  c = CTL_ADDI;
            default:  c = CTL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: two combinational read ports with WB->ID bypass, one
// write port on the rising edge, register 0 hardwired to zero.
module decode_regfile
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     ra1, ra2, wa;

    // Upper specifier bits beyond the register count are ignored
    assign ra1 = raddr1[AW-1:0];
    assign ra2 = raddr2[AW-1:0];
    assign wa  = waddr[AW-1:0];

    // Write port: clear on reset, writes to register 0 dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wdata;
        end
    end

    // Read ports: r0 reads zero, a same-cycle WB write is forwarded
    always_comb begin
        rdata1 = regs[ra1];
        rdata2 = regs[ra2];
        if (we && wa != '0 && wa == ra1) rdata1 = wdata;
        if (we && wa != '0 && wa == ra2) rdata2 = wdata;
        if (ra1 == '0) rdata1 = '0;
        if (ra2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS ID stage: control decode, load-use hazard detection, branch flush
// and the ID/EX pipeline register.
// Optional: define DECODE_PERF_EN to add saturating stall/bubble counters.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_id_valid,
    input  logic [31:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_npc,
    input  logic              ex_flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              id_stall,
    output logic              id_illegal,
    output logic              id_ex_valid,
    output logic [WB_W-1:0]   id_ex_wb,
    output logic [MEM_W-1:0]  id_ex_mem,
    output logic [EX_W-1:0]   id_ex_ex,
    output logic [DATA_W-1:0] id_ex_npc,
    output logic [DATA_W-1:0] id_ex_readdat1,
    output logic [DATA_W-1:0] id_ex_readdat2,
    output logic [DATA_W-1:0] id_ex_sign_ext,
    output logic [4:0]        id_ex_rs,
    output logic [4:0]        id_ex_rt,
    output logic [4:0]        id_ex_rd
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] rdata1, rdata2, sign_ext;
    ctl_t              ctl;
    logic              haz;
    logic              bubble;

    assign rs = if_id_instr[25:21];
    assign rt = if_id_instr[20:16];
    assign rd = if_id_instr[15:11];

    decode_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .we     (wb_reg_write),
        .waddr  (wb_write_reg),
        .wdata  (wb_write_data),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Decode, hazard detection and ID/EX load selection
    always_comb begin
        ctl      = decode_ctl(if_id_instr[31:26]);
        sign_ext = DATA_W'(signed'(if_id_instr[15:0]));
        // A pending WB write to the load target does not cancel the hazard
        haz = if_id_valid && id_ex_valid && id_ex_mem[MEM_READ] && id_ex_rt != 5'd0 &&
              (id_ex_rt == rs || (ctl.uses_rt && id_ex_rt == rt));
        id_stall   = haz && !ex_flush;
        id_illegal = if_id_valid && !ex_flush && !ctl.legal;
        bubble     = ex_flush || haz || !if_id_valid;
    end

    // ID/EX register: bubbles clear valid and control, data is don't-care
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_valid    <= 1'b0;
            id_ex_wb       <= '0;
            id_ex_mem      <= '0;
            id_ex_ex       <= '0;
            id_ex_npc      <= '0;
            id_ex_readdat1 <= '0;
            id_ex_readdat2 <= '0;
            id_ex_sign_ext <= '0;
            id_ex_rs       <= '0;
            id_ex_rt       <= '0;
            id_ex_rd       <= '0;
        end else if (bubble) begin
            id_ex_valid <= 1'b0;
            id_ex_wb    <= '0;
            id_ex_mem   <= '0;
            id_ex_ex    <= '0;
        end else begin
            id_ex_valid    <= 1'b1;
            id_ex_wb       <= ctl.wb;
            id_ex_mem      <= ctl.mem;
            id_ex_ex       <= ctl.ex;
            id_ex_npc      <= if_id_npc;
            id_ex_readdat1 <= rdata1;
            id_ex_readdat2 <= rdata2;
            id_ex_sign_ext <= sign_ext;
            id_ex_rs       <= rs;
            id_ex_rt       <= rt;
            id_ex_rd       <= rd;
        end
    end

`ifdef DECODE_PERF_EN
    // Saturating counters of stall cycles and bubbles that displaced a real instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (id_stall && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (bubble && if_id_valid && perf_bubble_cnt != '1) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: a driver applies directed then random
// instructions and queues expected results; two monitors pop and compare.
module tb_decode_stage_hz;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_id_valid = 1'b0;
    logic [31:0] if_id_instr = '0;
    logic [31:0] if_id_npc = '0;
    logic        ex_flush = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_reg = '0;
    logic [31:0] wb_write_data = '0;
    logic        id_stall, id_illegal, id_ex_valid;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

    decode_stage_hz #(.DATA_W(32), .NREGS(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_npc      (if_id_npc),
        .ex_flush       (ex_flush),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .id_stall       (id_stall),
        .id_illegal     (id_illegal),
        .id_ex_valid    (id_ex_valid),
        .id_ex_wb       (id_ex_wb),
        .id_ex_mem      (id_ex_mem),
        .id_ex_ex       (id_ex_ex),
        .id_ex_npc      (id_ex_npc),
        .id_ex_readdat1 (id_ex_readdat1),
        .id_ex_readdat2 (id_ex_readdat2),
        .id_ex_sign_ext (id_ex_sign_ext),
        .id_ex_rs       (id_ex_rs),
        .id_ex_rt       (id_ex_rt),
        .id_ex_rd       (id_ex_rd)
`ifdef DECODE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          illegal;
    } comb_exp_t;

    typedef struct {
        bit          valid;
        bit [1:0]    wb;
        bit [2:0]    mem;
        bit [3:0]    ex;
        bit          chk_data;
        bit [31:0]   npc, rd1, rd2, sext;
        bit [4:0]    rs, rt, rd;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural registers and the instruction now in EX
    bit [31:0] mregs [32];
    bit        m_valid = 0;
    bit        m_load = 0;
    bit [4:0]  m_rt = 0;
    bit        last_stall = 0;
    int        exp_stalls = 0;
    int        exp_bubbles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control table straight from the instruction set definition
    task automatic ctl_of(input bit [5:0] op, output bit legal, output bit uses_rt,
                          output bit [1:0] wb, output bit [2:0] mem, output bit [3:0] ex);
        legal = 1; uses_rt = 0; wb = 0; mem = 0; ex = 0;
        case (op)
            6'h00: begin wb = 2'b10; ex = 4'b1100; uses_rt = 1; end
            6'h23: begin wb = 2'b11; mem = 3'b010; ex = 4'b0001; end
            6'h2b: begin mem = 3'b001; ex = 4'b0001; uses_rt = 1; end
            6'h04: begin mem = 3'b100; ex = 4'b0100; uses_rt = 1; end
            6'h08: begin wb = 2'b10; ex = 4'b0001; end
            default: legal = 0;
        endcase
    endtask

    function automatic bit [31:0] model_read(input bit [4:0] idx, input bit we,
                                             input bit [4:0] wr, input bit [31:0] wd);
        if (idx == 0) return 32'd0;
        if (we && wr == idx) return wd;
        return mregs[idx];
    endfunction

    // One clock of stimulus; expectations are queued before the edge they describe
    task automatic step(input bit r, input bit v, input bit [31:0] ins, input bit fl,
                        input bit we, input bit [4:0] wr, input bit [31:0] wd);
        bit        legal, uses_rt, haz;
        bit [1:0]  wb;
        bit [2:0]  mem;
        bit [3:0]  ex;
        bit [4:0]  rs, rt;
        bit [31:0] npc;
        comb_exp_t ce;
        reg_exp_t  re;
        @(negedge clk);
        npc = $urandom;
        rst = r; if_id_valid = v; if_id_instr = ins; if_id_npc = npc; ex_flush = fl;
        wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
        #1;
        rs = ins[25:21];
        rt = ins[20:16];
        ctl_of(ins[31:26], legal, uses_rt, wb, mem, ex);
        haz = v && m_valid && m_load && m_rt != 0 && (m_rt == rs || (uses_rt && m_rt == rt));
        ce.stall   = haz && !fl;
        ce.illegal = v && !fl && !legal;
        comb_q.push_back(ce);
        last_stall = ce.stall;

        re = '{default: 0};
        if (r) begin
            re.chk_data = 1;
            m_valid = 0; m_load = 0;
            for (int i = 0; i < 32; i++) mregs[i] = 0;
            exp_stalls = 0; exp_bubbles = 0;
        end else begin
            if (ce.stall) exp_stalls++;
            if (fl || haz || !v) begin
                if (v) exp_bubbles++;
                m_valid = 0; m_load = 0;
            end else begin
                re.valid = 1; re.wb = wb; re.mem = mem; re.ex = ex; re.chk_data = 1;
                re.npc = npc;
                re.rd1 = model_read(rs, we, wr, wd);
                re.rd2 = model_read(rt, we, wr, wd);
                re.sext = {{16{ins[15]}}, ins[15:0]};
                re.rs = rs; re.rt = rt; re.rd = ins[15:11];
                m_valid = 1; m_load = (ins[31:26] == 6'h23); m_rt = rt;
            end
            if (we && wr != 0) mregs[wr] = wd;
        end
        reg_q.push_back(re);
    endtask

    // Combinational outputs, sampled just before the edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (comb_q.size() != 0) begin
                comb_exp_t e;
                e = comb_q.pop_front();
                check("id_stall", 64'(id_stall), 64'(e.stall));
                check("id_illegal", 64'(id_illegal), 64'(e.illegal));
            end
        end
    end

    // Registered outputs, sampled just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() != 0) begin
                reg_exp_t e;
                e = reg_q.pop_front();
                check("id_ex_valid", 64'(id_ex_valid), 64'(e.valid));
                check("id_ex_ctl", {52'd0, id_ex_wb, id_ex_mem, id_ex_ex},
                      {52'd0, e.wb, e.mem, e.ex});
                if (e.chk_data) begin
                    check("id_ex_npc", 64'(id_ex_npc), 64'(e.npc));
                    check("id_ex_readdat1", 64'(id_ex_readdat1), 64'(e.rd1));
                    check("id_ex_readdat2", 64'(id_ex_readdat2), 64'(e.rd2));
                    check("id_ex_sign_ext", 64'(id_ex_sign_ext), 64'(e.sext));
                    check("id_ex_regs", {49'd0, id_ex_rs, id_ex_rt, id_ex_rd},
                          {49'd0, e.rs, e.rt, e.rd});
                end
            end
        end
    end

    localparam bit [31:0] ADD_3_1_2  = 32'h0022_1820;
    localparam bit [31:0] LW_2_0_1   = 32'h8C22_0000;
    localparam bit [31:0] ADD_4_2_5  = 32'h0045_2020;
    localparam bit [31:0] LW_0_0_1   = 32'h8C20_0000;
    localparam bit [31:0] ADD_4_0_5  = 32'h0005_2020;
    localparam bit [31:0] ADDI_7_0_M = 32'h2007_FFFF;
    localparam bit [31:0] NOP_20     = 32'h8000_0000;

    initial begin
        bit [31:0] ins;
        bit [5:0]  ops [6];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b;
        ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h20;

        // Directed scenarios
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, ADD_3_1_2, 0, 0, 0, 0);
        step(0, 1, ADD_3_1_2, 0, 1, 5'd1, 32'hDEAD);
        step(0, 1, ADD_4_0_5, 0, 1, 5'd0, 32'd5);
        step(0, 1, ADD_4_0_5, 0, 0, 0, 0);
        step(0, 1, LW_2_0_1, 0, 0, 0, 0);
        step(0, 1, ADD_4_2_5, 0, 1, 5'd2, 32'h1234);
        step(0, 1, ADD_4_2_5, 0, 0, 0, 0);
        step(0, 1, LW_0_0_1, 0, 0, 0, 0);
        step(0, 1, ADD_4_0_5, 0, 0, 0, 0);
        step(0, 1, LW_2_0_1, 0, 0, 0, 0);
        step(0, 1, ADD_4_2_5, 1, 0, 0, 0);
        step(0, 1, ADDI_7_0_M, 1, 0, 0, 0);
        step(0, 1, NOP_20, 0, 0, 0, 0);
        step(0, 1, ADDI_7_0_M, 0, 0, 0, 0);
        step(0, 1, LW_2_0_1, 0, 0, 0, 0);
        step(1, 1, ADD_4_2_5, 0, 0, 0, 0);
        step(0, 1, ADD_4_2_5, 0, 0, 0, 0);

        // Random traffic; small register indices make hazards common
        for (int n = 0; n < 3000; n++) begin
            bit r, v, fl, we;
            bit [4:0] wr;
            r  = ($urandom_range(0, 99) < 2);
            v  = ($urandom_range(0, 99) < 85);
            fl = ($urandom_range(0, 99) < 10);
            we = $urandom_range(0, 1);
            wr = 5'($urandom_range(0, 7));
            if (!last_stall || $urandom_range(0, 3) == 0) begin
                ins = $urandom;
                ins[31:26] = ops[$urandom_range(0, 5)];
                ins[25:21] = 5'($urandom_range(0, 7));
                ins[20:16] = 5'($urandom_range(0, 7));
            end
            step(r, v, ins, fl, we, wr, $urandom);
        end

`ifdef DECODE_PERF_EN
        step(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(exp_stalls));
        check("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(exp_bubbles));
        step(1, 0, 0, 0, 0, 0, 0);
        #2;
        check("perf_stall_cnt_rst", 64'(perf_stall_cnt), 64'd0);
        check("perf_bubble_cnt_rst", 64'(perf_bubble_cnt), 64'd0);
`endif

        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("queues_drained", 64'(comb_q.size() + reg_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
